// File: rtl/mult4_share_ctrl.sv
// Two-requester sequencer for one shared external combinational 4x4 multiplier:
// round-robin grant, SETTLE-cycle settle wait, then a valid/ready response.
module mult4_share_ctrl #(
  parameter  int unsigned SETTLE = 1,
  localparam int unsigned OP_W   = 4,
  localparam int unsigned PROD_W = 2 * OP_W,
  localparam int unsigned DONE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_x,
  input  logic [OP_W-1:0]   req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_x,
  input  logic [OP_W-1:0]   req1_y,
  output logic [OP_W-1:0]   mul_x,
  output logic [OP_W-1:0]   mul_y,
  input  logic [PROD_W-1:0] mul_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy,
  output logic [DONE_W-1:0] done_cnt
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_live;
  logic                r_last;
  logic                r_rsp_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [OP_W-1:0]     r_mul_x;
  logic [OP_W-1:0]     r_mul_y;
  logic [PROD_W-1:0]   r_rsp_data;
  logic [DONE_W-1:0]   r_done_cnt;
  logic                w_gnt;
  logic                w_accept;
  logic                w_capture;
  logic                w_handshake;

  // Lone requester wins; on a tie the one not served last time wins.
  assign w_gnt = (req0_valid && req1_valid) ? ~r_last : req1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        // r_live keeps both readies low until the first edge after reset release.
        req0_ready = r_live && req0_valid && !w_gnt;
        req1_ready = r_live && req1_valid && w_gnt;
        if (r_live && (req0_valid || req1_valid)) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_last     <= 1'b1;
      r_rsp_id   <= 1'b0;
      r_cnt      <= '0;
      r_mul_x    <= '0;
      r_mul_y    <= '0;
      r_rsp_data <= '0;
      r_done_cnt <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_mul_x <= w_gnt ? req1_x : req0_x;
        r_mul_y <= w_gnt ? req1_y : req0_y;
        r_last  <= w_gnt;
        r_cnt   <= CNT_W'(SETTLE);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_rsp_data <= mul_o;
        r_rsp_id   <= r_last;
      end
      if (w_handshake) begin
        r_done_cnt <= r_done_cnt + DONE_W'(1);
      end
    end
  end

  assign mul_x     = r_mul_x;
  assign mul_y     = r_mul_y;
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_mult4_share_ctrl.sv
// Bench for mult4_share_ctrl: transaction-level model checked every cycle on a SETTLE=1
// instance, plus directed literal checks on it and on a SETTLE=15 instance.
module tb_mult4_share_ctrl;

  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n = 1'b0;
  logic       a_v0 = 1'b0, a_v1 = 1'b0, a_r0, a_r1;
  logic [3:0] a_x0 = 4'd0, a_y0 = 4'd0, a_x1 = 4'd0, a_y1 = 4'd0;
  logic [3:0] a_mx, a_my;
  logic [7:0] a_mo, a_rd, a_done;
  logic       a_rv, a_rr = 1'b0, a_rid, a_busy;

  logic       b_rst_n = 1'b0;
  logic       b_v0 = 1'b0, b_v1 = 1'b0, b_r0, b_r1;
  logic [3:0] b_x0 = 4'd0, b_y0 = 4'd0, b_x1 = 4'd0, b_y1 = 4'd0;
  logic [3:0] b_mx, b_my;
  logic [7:0] b_mo, b_rd, b_done;
  logic       b_rv, b_rr = 1'b0, b_rid, b_busy;

  // Ideal external multipliers
  assign a_mo = 8'(a_mx) * 8'(a_my);
  assign b_mo = 8'(b_mx) * 8'(b_my);

  mult4_share_ctrl #(.SETTLE(SETTLE_A)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .req0_valid(a_v0), .req0_ready(a_r0), .req0_x(a_x0), .req0_y(a_y0),
    .req1_valid(a_v1), .req1_ready(a_r1), .req1_x(a_x1), .req1_y(a_y1),
    .mul_x(a_mx), .mul_y(a_my), .mul_o(a_mo),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_data(a_rd), .rsp_id(a_rid),
    .busy(a_busy), .done_cnt(a_done)
  );

  mult4_share_ctrl #(.SETTLE(SETTLE_B)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .req0_valid(b_v0), .req0_ready(b_r0), .req0_x(b_x0), .req0_y(b_y0),
    .req1_valid(b_v1), .req1_ready(b_r1), .req1_x(b_x1), .req1_y(b_y1),
    .mul_x(b_mx), .mul_y(b_my), .mul_o(b_mo),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_data(b_rd), .rsp_id(b_rid),
    .busy(b_busy), .done_cnt(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic winner(input logic v0, input logic v1, input logic last);
    return (v0 && v1) ? !last : v1;
  endfunction

  // Transaction model: an op in flight is answered SETTLE edges after acceptance.
  int         cyc = 0;
  int         m_acc = 0;
  logic       cmp_en = 1'b0;
  logic       m_live = 1'b0, m_busy = 1'b0, m_resp = 1'b0, m_last = 1'b1;
  logic       m_id = 1'b0, m_rid = 1'b0, mdl_w, cmp_w;
  logic [3:0] m_mx = 4'd0, m_my = 4'd0;
  logic [7:0] m_prod = 8'd0, m_rdata = 8'd0, m_done = 8'd0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!a_rst_n) begin
      m_live = 1'b0; m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b1;
      m_rid = 1'b0; m_rdata = 8'd0; m_done = 8'd0; m_mx = 4'd0; m_my = 4'd0;
      cmp_en = 1'b1;
    end else begin
      mdl_w = winner(a_v0, a_v1, m_last);
      if (m_live && !m_busy && (a_v0 || a_v1)) begin
        m_busy = 1'b1; m_acc = cyc; m_id = mdl_w; m_last = mdl_w;
        m_mx = mdl_w ? a_x1 : a_x0;
        m_my = mdl_w ? a_y1 : a_y0;
        m_prod = 8'(m_mx) * 8'(m_my);
      end else if (m_resp && a_rr) begin
        m_busy = 1'b0; m_resp = 1'b0; m_done = m_done + 8'd1;
      end else if (m_busy && !m_resp && cyc == m_acc + SETTLE_A) begin
        m_resp = 1'b1; m_rdata = m_prod; m_rid = m_id;
      end
      m_live = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      cmp_w = winner(a_v0, a_v1, m_last);
      chkb("req0_ready", a_r0, m_live && !m_busy && a_v0 && !cmp_w);
      chkb("req1_ready", a_r1, m_live && !m_busy && a_v1 && cmp_w);
      chkb("busy", a_busy, m_busy);
      chkb("rsp_valid", a_rv, m_resp);
      chk8("rsp_data", a_rd, m_rdata);
      chkb("rsp_id", a_rid, m_rid);
      chk8("mul_x", 8'(a_mx), 8'(m_mx));
      chk8("mul_y", 8'(a_my), 8'(m_my));
      chk8("done_cnt", a_done, m_done);
    end
  end

  logic [8:0] rq[$];
  initial forever begin
    @(negedge clk);
    if (a_rv && a_rr) rq.push_back({a_rid, a_rd});
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic accept_a(input logic id, input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    if (id) begin a_v1 = 1'b1; a_x1 = x; a_y1 = y; end
    else    begin a_v0 = 1'b1; a_x0 = x; a_y0 = y; end
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? a_r1 : a_r0) && n < 20);
    chkb("accept_a", id ? a_r1 : a_r0, 1'b1);
    @(posedge clk); #1;
    a_v0 = 1'b0;
    a_v1 = 1'b0;
  endtask

  task automatic wait_idle_a(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_busy && n < lim);
    chkb("idle_a", a_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d0;
    int n, nw, first;

    // Reset with req0 already presenting 15x15
    a_v0 = 1'b1; a_x0 = 4'd15; a_y0 = 4'd15; a_rr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_req0_ready", a_r0, 1'b0);
    chkb("rst_rsp_valid", a_rv, 1'b0);
    chkb("rst_busy", a_busy, 1'b0);
    chk8("rst_done", a_done, 8'd0);
    chk8("rst_mul_x", 8'(a_mx), 8'd0);
    chkb("rst_rsp_id", a_rid, 1'b0);
    @(posedge clk); #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    chkb("release_ready_low", a_r0, 1'b0);
    @(posedge clk); #1;

    // Single op 15x15, SETTLE=1
    accept_a(1'b0, 4'd15, 4'd15);
    @(negedge clk);
    chkb("s1_busy", a_busy, 1'b1);
    chkb("s1_wait_valid", a_rv, 1'b0);
    chk8("s1_mul_x", 8'(a_mx), 8'd15);
    @(negedge clk);
    chkb("s1_rsp_valid", a_rv, 1'b1);
    chk8("s1_rsp_data", a_rd, 8'd225);
    chkb("s1_rsp_id", a_rid, 1'b0);
    @(negedge clk);
    chk8("s1_done", a_done, 8'd1);
    chkb("s1_idle", a_busy, 1'b0);

    // Tie arbitration after a fresh reset
    @(posedge clk); #1; a_rst_n = 1'b0;
    @(posedge clk); #1; a_rst_n = 1'b1;
    rq.delete();
    a_v0 = 1'b1; a_x0 = 4'd3; a_y0 = 4'd5;
    a_v1 = 1'b1; a_x1 = 4'd7; a_y1 = 4'd9;
    for (int k = 0; k < 60 && rq.size() < 4; k++) begin
      @(posedge clk); #1;
    end
    a_v0 = 1'b0; a_v1 = 1'b0;
    wait_idle_a(20);
    chkb("tie_count", rq.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < rq.size()) begin
        chkb("tie_id", rq[i][8], 1'(i % 2));
        chk8("tie_data", rq[i][7:0], (i % 2 == 1) ? 8'd63 : 8'd15);
      end
    end

    // Backpressure: response held 10+ cycles with both requesters asking
    @(posedge clk); #1;
    a_rr = 1'b0;
    accept_a(1'b0, 4'd9, 4'd6);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_rv && n < 10);
    chkb("bp_rsp_seen", a_rv, 1'b1);
    @(posedge clk); #1;
    a_v0 = 1'b1; a_v1 = 1'b1;
    d0 = m_done;
    repeat (10) begin
      @(negedge clk);
      chkb("bp_rsp_valid", a_rv, 1'b1);
      chk8("bp_rsp_data", a_rd, 8'd54);
      chkb("bp_req0_ready", a_r0, 1'b0);
      chkb("bp_req1_ready", a_r1, 1'b0);
      chk8("bp_done_hold", a_done, d0);
    end
    @(posedge clk); #1;
    a_v0 = 1'b0; a_v1 = 1'b0; a_rr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk8("bp_done_inc", a_done, d0 + 8'd1);
    chkb("bp_rsp_gone", a_rv, 1'b0);

    // Reset during WAIT discards the operation
    @(posedge clk); #1;
    accept_a(1'b1, 4'd4, 4'd4);
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1; a_v0 = 1'b1;
    @(negedge clk);
    chkb("mid_busy", a_busy, 1'b0);
    chkb("mid_rsp_valid", a_rv, 1'b0);
    chk8("mid_rsp_data", a_rd, 8'd0);
    chk8("mid_mul_x", 8'(a_mx), 8'd0);
    chk8("mid_mul_y", 8'(a_my), 8'd0);
    chk8("mid_done", a_done, 8'd0);
    chkb("mid_req0_ready", a_r0, 1'b0);
    @(posedge clk); #1;
    a_v0 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chkb("mid_no_rsp", a_rv, 1'b0);
    end

    // Exhaustive operand sweep, 256 ops, done_cnt wraps to 0
    @(posedge clk); #1;
    a_rr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      accept_a(1'(i), 4'(i >> 4), 4'(i));
      wait_idle_a(10);
      if (i == 254) chk8("wrap_255", a_done, 8'd255);
      @(posedge clk); #1;
    end
    chk8("wrap_0", a_done, 8'd0);

    // SETTLE=15 instance: 15 WAIT cycles, response in the 16th cycle
    b_v1 = 1'b1; b_x1 = 4'd13; b_y1 = 4'd11;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_r1 && n < 20);
    chkb("s15_accept", b_r1, 1'b1);
    chkb("s15_req0_ready", b_r0, 1'b0);
    @(posedge clk); #1;
    b_v1 = 1'b0;
    nw = 0;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (b_rv) begin
        first = k;
        break;
      end
      if (b_busy) nw++;
    end
    chki("s15_wait_cycles", nw, 15);
    chki("s15_latency", first, 16);
    chk8("s15_rsp_data", b_rd, 8'd143);
    chkb("s15_rsp_id", b_rid, 1'b1);
    chk8("s15_mul_x", 8'(b_mx), 8'd13);
    @(posedge clk); #1;
    b_rr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk8("s15_done", b_done, 8'd1);
    chkb("s15_idle", b_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult4_share_ctrl.md
MULT4_SHARE_CTRL -- requirements
Module: mult4_share_ctrl

Interface
REQ-001 Parameter: SETTLE, 1, number of WAIT cycles allowed for the external combinational 4x4 multiplier to settle. Legal range is 1..15.
REQ-002 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n  in  1  synchronous, active-low reset.
REQ-004 Port: req0_valid  in  1  requester 0 has an operand pair.
REQ-005 Port: req0_ready  out  1  requester 0 pair is accepted this cycle.
REQ-006 Port: req0_x, req0_y  in  4 each  requester 0 unsigned operands.
REQ-007 Port: req1_valid, req1_ready, req1_x, req1_y  same as REQ-004..006, for requester 1.
REQ-008 Port: mul_x, mul_y  out  4 each  registered operands driven to the shared multiplier.
REQ-009 Port: mul_o  in  8  product returned by the shared multiplier.
REQ-010 Port: rsp_valid  out  1  a result is presented.
REQ-011 Port: rsp_ready  in  1  the consumer takes the result.
REQ-012 Port: rsp_data  out  8  captured product.
REQ-013 Port: rsp_id  out  1  index of the requester that owns rsp_data.
REQ-014 Port: busy  out  1  high whenever state is not IDLE.
REQ-015 Port: done_cnt  out  8  count of completed responses.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-017 In IDLE, req_ready SHALL be high only for the granted requester, and only while that requester's valid is high; both ready outputs SHALL be low in WAIT and RESP.
REQ-018 Grant rule: a single valid request wins; if both are valid, the requester not granted last time wins (round-robin).
REQ-019 Grant history after reset SHALL make requester 0 win the first tie.
REQ-020 Acceptance event (valid and ready at a rising edge) SHALL:
- latch the operands into mul_x/mul_y;
- latch the requester index;
- update the grant history;
- load the settle counter with SETTLE;
- move the FSM to WAIT.
REQ-021 In WAIT, the counter SHALL decrement once per cycle; on the edge where it equals 1, the block SHALL capture mul_o into rsp_data, set rsp_id, and move to RESP.
REQ-022 Latency: the first rsp_valid cycle SHALL be SETTLE+1 cycles after the acceptance edge.
REQ-023 In RESP, rsp_valid SHALL be high, and rsp_data/rsp_id SHALL stay stable until rsp_ready is sampled high.
REQ-024 On the response handshake, the FSM SHALL return to IDLE and done_cnt SHALL increment, wrapping 255->0.
REQ-025 No request SHALL be accepted in the response-handshake cycle; sustained throughput is one operation per SETTLE+2 cycles.
REQ-026 mul_x/mul_y SHALL hold the last accepted operands until the next acceptance.
REQ-027 Request inputs SHALL be ignored while the corresponding ready is low.
- A requester may drop valid before acceptance with no effect.
- Operand changes while not accepted SHALL have no effect.
REQ-028 rsp_data SHALL equal the unsigned product x*y (0..225) of the accepted pair, provided mul_o is correct.

Reset
REQ-029 When rst_n is sampled low at a rising edge, the block SHALL reset as follows:
- state = IDLE, counter = 0, rsp_id = 0, grant history = requester 1;
- the outputs below are low/zero until the first edge after rst_n returns high: mul_x, mul_y, rsp_valid, rsp_data, done_cnt, busy, req0_ready, req1_ready.
REQ-030 Reset asserted in WAIT or RESP SHALL discard the in-flight operation: no response is produced and done_cnt is not incremented.

Verification
REQ-031 Single op, SETTLE=1: req0 presents x=15, y=15 and is accepted at edge E, rsp_ready held high.
-> rsp_valid high in cycle E+2, rsp_data=225, rsp_id=0, done_cnt=1.
REQ-032 Tie arbitration: both requesters hold valid continuously (req0 3x5, req1 7x9).
-> responses alternate id 0,1,0,1 with data 15,63,15,63; first grant is to req0.
REQ-033 Backpressure: rsp_ready held low for 10 cycles while in RESP.
-> rsp_valid and rsp_data stay constant; both ready outputs low; done_cnt unchanged until the handshake.
REQ-034 Reset mid-op: rst_n low for one edge during WAIT.
-> next cycle: all outputs zero; no rsp_valid appears afterwards without a new acceptance.
REQ-035 done_cnt wrap: complete 256 operations.
-> done_cnt reads 0 after the 256th handshake; data is correct for an exhaustive sweep of all 256 operand pairs.
REQ-036 SETTLE=15: single accepted op.
-> exactly 15 WAIT cycles; rsp_valid first high 16 cycles after the acceptance edge.
